// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite initiator that turns a cmd/rsp valid-ready stream into AXI-Lite reads and writes.
// Zero-wait latency is accept at cycle 0 and rsp_valid at cycle 3, one command per 5 cycles; rsp held until rsp_ready, no new cmd while busy.
module axil_cmd_master #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH/8,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [15:0]           err_count,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int ALIGN = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << ALIGN) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                state_q, state_n;
  logic                  cmd_ready_q, cmd_ready_n;
  logic                  aw_done_q, aw_done_n;
  logic                  w_done_q, w_done_n;
  logic                  write_q, write_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [1:0]            resp_q, resp_n;
  logic [15:0]           err_q, err_n;
  logic                  capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      err_q       <= 16'h0000;
    end else begin
      state_q     <= state_n;
      cmd_ready_q <= cmd_ready_n;
      aw_done_q   <= aw_done_n;
      w_done_q    <= w_done_n;
      write_q     <= write_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      rdata_q     <= rdata_n;
      resp_q      <= resp_n;
      err_q       <= err_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    aw_done_n = aw_done_q;
    w_done_n  = w_done_q;
    write_n   = write_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    rdata_n   = rdata_q;
    resp_n    = resp_q;
    err_n     = err_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_n    = cmd_addr & ADDR_MASK;
          wdata_n   = cmd_wdata;
          wstrb_n   = cmd_wstrb;
          write_n   = cmd_write;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; either order or the same cycle.
        aw_done_n = aw_done_q | (m_axil_awvalid & m_axil_awready);
        w_done_n  = w_done_q | (m_axil_wvalid & m_axil_wready);
        if (aw_done_n && w_done_n) state_n = WR_RESP;
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          resp_n  = m_axil_bresp;
          rdata_n = '0;
          write_n = 1'b1;
          capture = 1'b1;
          state_n = RSP;
        end
      end
      RD_REQ: begin
        if (m_axil_arready) state_n = RD_RESP;
      end
      RD_RESP: begin
        if (m_axil_rvalid) begin
          resp_n  = m_axil_rresp;
          rdata_n = m_axil_rdata;
          write_n = 1'b0;
          capture = 1'b1;
          state_n = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Registered ready lags the IDLE state by a cycle, giving the 5-cycle command period.
    cmd_ready_n = (state_q == IDLE) && !(cmd_valid && cmd_ready_q);
    if (capture && resp_n != 2'b00 && err_q != 16'hFFFF) err_n = err_q + 16'd1;
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = (state_q != IDLE);
  assign rsp_valid      = (state_q == RSP);
  assign rsp_write      = write_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign err_count      = err_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axil_bready  = (state_q == WR_RESP);
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = (state_q == RD_REQ);
  assign m_axil_rready  = (state_q == RD_RESP);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a negedge-driven AXI-Lite slave model and RAM.
module tb_axil_cmd_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;
  logic        busy;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  axil_cmd_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count), .busy(busy),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Slave configuration, written only by the stimulus process.
  int          aw_wait = 0, w_wait = 0, r_wait = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  logic        r_from_mem = 1'b1;
  logic [31:0] aw_exp = 32'h0;

  // Slave observations, written only by the slave process.
  int          aw_vld_cycles = 0, w_vld_cycles = 0, aw_bad = 0, bready_early = 0, b_count = 0;
  logic [31:0] ar_seen = 32'h0;
  logic [31:0] mem [logic [31:0]];

  initial begin : slave
    int          aw_cnt, w_cnt, r_cnt;
    logic        aw_got, w_got, r_pend, b_rdy_seen, r_rdy_seen;
    logic [31:0] wr_addr, wr_data, word;
    logic [3:0]  wr_strb;
    aw_cnt = 0; w_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; r_pend = 0; b_rdy_seen = 0; r_rdy_seen = 0;
    wr_addr = 0; wr_data = 0; wr_strb = 0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
    m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rresp = 0; m_axil_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; r_pend = 0; b_rdy_seen = 0; r_rdy_seen = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
        m_axil_arready = 0; m_axil_rvalid = 0;
      end else begin
        // Retire handshakes completed at the preceding posedge.
        if (m_axil_awready) begin m_axil_awready = 0; aw_got = 1; end
        if (m_axil_wready)  begin m_axil_wready = 0;  w_got = 1;  end
        if (m_axil_bvalid && b_rdy_seen) m_axil_bvalid = 0;
        if (m_axil_rvalid && r_rdy_seen) m_axil_rvalid = 0;
        if (m_axil_arready) begin
          m_axil_arready = 0; r_pend = 1; r_cnt = r_wait;
        end
        if (m_axil_awvalid) begin
          aw_vld_cycles++;
          if (m_axil_awaddr !== aw_exp) aw_bad++;
          if (aw_cnt == aw_wait) begin m_axil_awready = 1; aw_cnt = 0; wr_addr = m_axil_awaddr; end
          else aw_cnt++;
        end
        if (m_axil_wvalid) begin
          w_vld_cycles++;
          if (w_cnt == w_wait) begin
            m_axil_wready = 1; w_cnt = 0; wr_data = m_axil_wdata; wr_strb = m_axil_wstrb;
          end else w_cnt++;
        end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          word = mem.exists(wr_addr) ? mem[wr_addr] : 32'h0;
          for (int i = 0; i < 4; i++) if (wr_strb[i]) word[8*i +: 8] = wr_data[8*i +: 8];
          mem[wr_addr] = word;
          m_axil_bvalid = 1; m_axil_bresp = b_resp_cfg; b_count++;
        end
        if (m_axil_arvalid) begin m_axil_arready = 1; ar_seen = m_axil_araddr; end
        if (r_pend) begin
          if (r_cnt == 0) begin
            r_pend = 0; m_axil_rvalid = 1; m_axil_rresp = r_resp_cfg;
            m_axil_rdata = r_from_mem ? (mem.exists(ar_seen) ? mem[ar_seen] : 32'h0) : r_data_cfg;
          end else r_cnt--;
        end
        if (m_axil_bready && !m_axil_bvalid) bready_early++;
        b_rdy_seen = m_axil_bready;
        r_rdy_seen = m_axil_rready;
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int acc);
    int n;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rc);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("rsp_arrive", {31'd0, rsp_valid}, 32'd1);
    rc = cyc;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin : stim
    int a, a2, rc, aw0, w0, be0, b0, bad0, stab_bad;
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_outputs", {26'd0, rsp_valid, m_axil_awvalid, m_axil_wvalid,
                          m_axil_arvalid, m_axil_bready, m_axil_rready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write then read-back.
    aw_exp = 32'h100;
    send(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, a);
    check("wr_lat_aw", {30'd0, m_axil_awvalid, m_axil_wvalid}, 32'd3);
    check("wr_awaddr", m_axil_awaddr, 32'h100);
    wait_rsp(rc);
    check("wr_rsp_cycle", rc - a, 32'd3);
    check("wr_rsp", {28'd0, rsp_write, 1'b0, rsp_resp}, 32'h8);
    check("wr_rdata0", rsp_rdata, 32'd0);
    consume();
    send(1'b0, 32'h100, 32'h0, 4'h0, a);
    check("rd_arvalid", {31'd0, m_axil_arvalid}, 32'd1);
    wait_rsp(rc);
    check("rd_rsp_cycle", rc - a, 32'd3);
    check("rd_readback", rsp_rdata, 32'hDEADBEEF);
    check("rd_write_flag", {31'd0, rsp_write}, 32'd0);
    consume();

    // Back-to-back throughput with rsp_ready held high.
    rsp_ready = 1'b1;
    aw_exp = 32'h180;
    send(1'b1, 32'h180, 32'h11111111, 4'hF, a);
    send(1'b1, 32'h180, 32'h22222222, 4'h3, a2);
    check("throughput", a2 - a, 32'd5);
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
    check("tp_idle", {31'd0, busy}, 32'd0);
    r_from_mem = 1'b1;
    send(1'b0, 32'h180, 32'h0, 4'h0, a);
    wait_rsp(rc);
    check("tp_strb_merge", rsp_rdata, 32'h11112222);
    consume();

    // AW delayed, W immediate.
    aw_wait = 3; aw_exp = 32'h200;
    aw0 = aw_vld_cycles; w0 = w_vld_cycles; be0 = bready_early; b0 = b_count; bad0 = aw_bad;
    send(1'b1, 32'h200, 32'h12345678, 4'hF, a);
    wait_rsp(rc);
    check("skew_aw_cycles", aw_vld_cycles - aw0, 32'd4);
    check("skew_w_cycles", w_vld_cycles - w0, 32'd1);
    check("skew_aw_stable", aw_bad - bad0, 32'd0);
    check("skew_bready_early", bready_early - be0, 32'd0);
    check("skew_rsp_cycle", rc - a, 32'd6);
    consume();
    repeat (3) @(negedge clk);
    check("skew_one_b", b_count - b0, 32'd1);
    aw_wait = 0;

    // Unaligned read with delayed R.
    r_wait = 6; r_from_mem = 1'b0; r_data_cfg = 32'h55;
    send(1'b0, 32'h0400_0003, 32'h0, 4'h0, a);
    wait_rsp(rc);
    check("unal_araddr", ar_seen, 32'h0400_0000);
    check("unal_rdata", rsp_rdata, 32'h55);
    check("unal_write", {31'd0, rsp_write}, 32'd0);
    check("unal_rsp_cycle", rc - a, 32'd9);
    consume();
    r_wait = 0;

    // SLVERR write with response backpressure.
    b_resp_cfg = 2'b10; aw_exp = 32'h300;
    send(1'b1, 32'h300, 32'hCAFE0000, 4'hC, a);
    wait_rsp(rc);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h300;
    stab_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_resp !== 2'b10 || !rsp_write || rsp_rdata !== 32'h0 || cmd_ready)
        stab_bad++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp_stable", stab_bad, 32'd0);
    check("bp_err_count", {16'd0, err_count}, 32'd1);
    consume();
    b_resp_cfg = 2'b00;

    // Saturation.
    force dut.err_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_q;
    @(negedge clk);
    r_resp_cfg = 2'b10;
    send(1'b0, 32'h100, 32'h0, 4'h0, a);
    wait_rsp(rc);
    check("sat_resp", {30'd0, rsp_resp}, 32'd2);
    check("sat_first", {16'd0, err_count}, 32'hFFFF);
    consume();
    send(1'b0, 32'h100, 32'h0, 4'h0, a);
    wait_rsp(rc);
    consume();
    check("sat_hold", {16'd0, err_count}, 32'hFFFF);
    r_resp_cfg = 2'b00;

    // Reset while waiting in RD_RESP.
    r_wait = 20;
    send(1'b0, 32'h500, 32'h0, 4'h0, a);
    @(negedge clk);
    check("mid_rready_pre", {31'd0, m_axil_rready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outs", {29'd0, m_axil_arvalid, m_axil_rready, rsp_valid}, 32'd0);
    check("mid_rst_ready", {30'd0, cmd_ready, busy}, 32'd2);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    r_wait = 0; r_from_mem = 1'b1;
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    send(1'b0, 32'h100, 32'h0, 4'h0, a);
    wait_rsp(rc);
    check("post_rst_rdata", rsp_rdata, 32'hDEADBEEF);
    check("post_rst_cycle", rc - a, 32'd3);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
